// File: rtl/sort_sequencer.sv
// sort_sequencer -- built-in self-test initiator for the sorter blocks.
//
// Generates a pseudo-random array (element k = ((k+1)*Mult) mod MODULUS),
// hands it to a sorter with a Start pulse, waits for Done, then serially
// checks the returned array for ascending order and an element-sum match.
// Finally it releases the sorter with Ack and reports Pass/Fail.
//
// Ports:
//   Clk, Reset    clock (rising edge), asynchronous active-low reset
//   Go            one-cycle run request, honoured only when idle
//   Mult, Width   generator multiplier and element count, sampled on Go
//   Ain           generated array, element k at [k*W +: W]
//   Start         one-cycle start pulse to the sorter
//   Aout, Done    sorted array and level completion flag from the sorter
//   Ack           one-cycle release pulse to the sorter
//   Busy          run in progress
//   Pass, Fail    result flags, held until the next accepted Go
//   ErrCode       0 none, 1 bad width, 2 order, 3 checksum, 4 timeout
//   ErrIdx        first k with Aout[k] > Aout[k+1]
//   Cycles        Start-to-Done cycle count, saturating
//   DbgState      current FSM state encoding
//
// Sorter handshake: Start is a single-cycle pulse once Ain is stable. The
// sorter raises Done (a level) when Aout is valid; Aout is captured on the
// first WAIT cycle with Done high. After checking, Ack pulses for one cycle
// to let the sorter drop Done. A timeout or a reset skips Ack entirely.
module sort_sequencer #(
    parameter int N       = 30,
    parameter int W       = 7,
    parameter int MODULUS = 113,
    parameter int TIMEOUT = 65535
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Go,
    input  logic [W-1:0]   Mult,
    input  logic [4:0]     Width,
    output logic [N*W-1:0] Ain,
    output logic           Start,
    input  logic [N*W-1:0] Aout,
    input  logic           Done,
    output logic           Ack,
    output logic           Busy,
    output logic           Pass,
    output logic           Fail,
    output logic [2:0]     ErrCode,
    output logic [4:0]     ErrIdx,
    output logic [15:0]    Cycles,
    output logic [2:0]     DbgState
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_START, S_WAIT, S_CHECK, S_ACK, S_REPORT
    } state_t;

    localparam int          SW    = 12;
    localparam logic [4:0]  N5    = N[4:0];
    localparam logic [W:0]  MOD_X = MODULUS[W:0];
    localparam logic [16:0] TO_X  = TIMEOUT[16:0];

    state_t          state_q, state_d;
    logic [4:0]      width_q, width_d;
    logic [W-1:0]    mult_q, mult_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [4:0]      k_q, k_d;
    logic [SW-1:0]   in_sum_q, in_sum_d;
    logic [SW-1:0]   out_sum_q, out_sum_d;
    logic [N*W-1:0]  ain_q, ain_d;
    logic [N*W-1:0]  cap_q, cap_d;
    logic            busy_q, busy_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic [2:0]      err_q, err_d;
    logic [4:0]      idx_q, idx_d;
    logic [15:0]     cyc_q, cyc_d;

    logic [W:0]      acc_sum, acc_wrap;
    logic [W-1:0]    acc_nxt;
    logic [15:0]     cyc_inc;
    logic            k_last;
    logic [4:0]      k_nxt;
    logic [W-1:0]    cur_el, nxt_el;
    logic [SW-1:0]   osum_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            in_sum_q  <= '0;
            out_sum_q <= '0;
            ain_q     <= '0;
            cap_q     <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= '0;
            idx_q     <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            in_sum_q  <= in_sum_d;
            out_sum_q <= out_sum_d;
            ain_q     <= ain_d;
            cap_q     <= cap_d;
            busy_q    <= busy_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        k_d       = k_q;
        in_sum_d  = in_sum_q;
        out_sum_d = out_sum_q;
        ain_d     = ain_q;
        cap_d     = cap_q;
        busy_d    = busy_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;

        // Incremental residue: both operands are already below MODULUS,
        // so a single conditional subtract keeps acc in range.
        acc_sum  = {1'b0, acc_q} + {1'b0, mult_q};
        acc_wrap = acc_sum - MOD_X;
        acc_nxt  = (acc_sum >= MOD_X) ? acc_wrap[W-1:0] : acc_sum[W-1:0];

        cyc_inc  = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        k_last   = (k_q == width_q - 5'd1);
        // Clamp the neighbour index so the top element never reads past
        // the array; that comparison is masked by k_last anyway.
        k_nxt    = (k_q == N5 - 5'd1) ? k_q : k_q + 5'd1;
        cur_el   = cap_q[k_q*W +: W];
        nxt_el   = cap_q[k_nxt*W +: W];
        osum_nxt = out_sum_q + {{(SW-W){1'b0}}, cur_el};

        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    mult_d    = ({1'b0, Mult} >= MOD_X) ? Mult - MOD_X[W-1:0] : Mult;
                    width_d   = Width;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    err_d     = 3'd0;
                    idx_d     = 5'd0;
                    cyc_d     = 16'd0;
                    acc_d     = '0;
                    k_d       = 5'd0;
                    in_sum_d  = '0;
                    out_sum_d = '0;
                    ain_d     = '0;
                    if (Width == 5'd0 || Width > N5) begin
                        err_d   = 3'd1;
                        state_d = S_REPORT;
                    end else begin
                        state_d = S_GEN;
                    end
                end
            end
            S_GEN: begin
                ain_d[k_q*W +: W] = acc_nxt;
                acc_d    = acc_nxt;
                in_sum_d = in_sum_q + {{(SW-W){1'b0}}, acc_nxt};
                if (k_last) begin
                    k_d     = 5'd0;
                    state_d = S_START;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                cyc_d = cyc_inc;
                if (Done) begin
                    cap_d   = Aout;
                    state_d = S_CHECK;
                end else if ({1'b0, cyc_inc} >= TO_X) begin
                    err_d   = 3'd4;
                    state_d = S_REPORT;
                end
            end
            S_CHECK: begin
                out_sum_d = osum_nxt;
                // Only the first violation is kept; scanning continues so
                // the output sum still covers every element.
                if (!k_last && (cur_el > nxt_el) && (err_q == 3'd0)) begin
                    err_d = 3'd2;
                    idx_d = k_q;
                end
                if (k_last) begin
                    if ((err_q == 3'd0) && (osum_nxt != in_sum_q)) begin
                        err_d = 3'd3;
                    end
                    k_d     = 5'd0;
                    state_d = S_ACK;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_ACK: state_d = S_REPORT;
            S_REPORT: begin
                pass_d  = (err_q == 3'd0);
                fail_d  = (err_q != 3'd0);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Ain      = ain_q;
    assign Start    = (state_q == S_START);
    assign Ack      = (state_q == S_ACK);
    assign Busy     = busy_q;
    assign Pass     = pass_q;
    assign Fail     = fail_q;
    assign ErrCode  = err_q;
    assign ErrIdx   = idx_q;
    assign Cycles   = cyc_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer: a table of directed runs against a bench-side
// sorter model, plus hand-written sequences for Go-while-busy and reset
// during WAIT.
module tb_sort_sequencer;

    localparam int N   = 30;
    localparam int W   = 7;
    localparam int MOD = 113;
    localparam int TO  = 100;
    localparam int L   = 3;     // sorter model Done latency after Start

    logic           Clk   = 1'b0;
    logic           Reset = 1'b0;
    logic           Go    = 1'b0;
    logic [W-1:0]   Mult  = '0;
    logic [4:0]     Width = '0;
    logic [N*W-1:0] Ain;
    logic [N*W-1:0] Aout  = '0;
    logic           Done  = 1'b0;
    logic           Start, Ack, Busy, Pass, Fail;
    logic [2:0]     ErrCode, DbgState;
    logic [4:0]     ErrIdx;
    logic [15:0]    Cycles;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int ack_cnt   = 0;
    int model_mode  = 0;   // 0 good, 1 swap 4/5, 2 last+1, 3 never Done
    int model_width = 0;
    int cnt = 0;
    int sa [N];
    logic [W-1:0] exp_q[$];

    typedef struct {
        int mult;
        int width;
        int mode;
        bit exp_pass;
        int exp_err;
        int exp_idx;
        int exp_cyc;
        int exp_start;
        int exp_ack;
    } vec_t;

    vec_t vecs [9];

    sort_sequencer #(.N(N), .W(W), .MODULUS(MOD), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .Mult(Mult), .Width(Width),
        .Ain(Ain), .Start(Start), .Aout(Aout), .Done(Done), .Ack(Ack),
        .Busy(Busy), .Pass(Pass), .Fail(Fail), .ErrCode(ErrCode),
        .ErrIdx(ErrIdx), .Cycles(Cycles), .DbgState(DbgState)
    );

    // clock
    always #5 Clk = ~Clk;

    // sorter model, acting on the falling edge
    always @(negedge Clk) begin
        if (!Reset) begin
            Done = 1'b0;
            cnt  = 0;
        end else begin
            if (Ack) begin
                ack_cnt++;
                Done = 1'b0;
            end
            if (Start) begin
                start_cnt++;
                cnt = (model_mode == 3) ? 0 : L;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    for (int i = 0; i < N; i++)
                        sa[i] = (i < model_width) ? int'(Ain[i*W +: W]) : 0;
                    for (int i = 0; i < model_width; i++)
                        for (int j = 0; j < model_width - 1 - i; j++)
                            if (sa[j] > sa[j+1]) begin
                                int t;
                                t = sa[j]; sa[j] = sa[j+1]; sa[j+1] = t;
                            end
                    if (model_mode == 1) begin
                        int t;
                        t = sa[4]; sa[4] = sa[5]; sa[5] = t;
                    end
                    if (model_mode == 2) sa[model_width-1] = sa[model_width-1] + 1;
                    for (int i = 0; i < N; i++) Aout[i*W +: W] = W'(sa[i]);
                    Done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_go(input int m, input int w);
        @(negedge Clk);
        Mult  = W'(m);
        Width = 5'(w);
        Go    = 1'b1;
        @(negedge Clk);
        Go    = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int lat);
        lat = 1;
        while (!(Pass || Fail) && lat < 2000) begin
            @(negedge Clk);
            lat++;
        end
        if (lat >= 2000) check({tag, "_wait_expired"}, 32'd1, 32'd0);
    endtask

    // scoreboard: expected Ain elements queued, then popped against the DUT
    task automatic check_ain(input string tag, input int m, input int w);
        logic [W-1:0] e;
        for (int k = 0; k < N; k++)
            exp_q.push_back((k < w) ? W'(((k + 1) * m) % MOD) : '0);
        for (int k = 0; k < N; k++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_ain%0d", tag, k), 32'(Ain[k*W +: W]), 32'(e));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0, a0, lat;
        s0 = start_cnt;
        a0 = ack_cnt;
        model_mode  = v.mode;
        model_width = v.width;
        pulse_go(v.mult, v.width);
        wait_result(tag, lat);
        check({tag, "_pass"},  32'(Pass), 32'(v.exp_pass));
        check({tag, "_fail"},  32'(Fail), 32'(!v.exp_pass));
        check({tag, "_err"},   32'(ErrCode), 32'(v.exp_err));
        check({tag, "_idx"},   32'(ErrIdx), 32'(v.exp_idx));
        check({tag, "_cyc"},   32'(Cycles), 32'(v.exp_cyc));
        check({tag, "_busy"},  32'(Busy), 32'd0);
        check({tag, "_start"}, 32'(start_cnt - s0), 32'(v.exp_start));
        check({tag, "_ack"},   32'(ack_cnt - a0), 32'(v.exp_ack));
        if (v.exp_err == 1) begin
            check({tag, "_lat"}, 32'(lat <= 2), 32'd1);
        end else if (v.exp_err != 4) begin
            // n gen + start + L wait + n check + ack + report, within +-1
            check({tag, "_lat"},
                  32'((lat >= 2*v.width + L + 2) && (lat <= 2*v.width + L + 4)), 32'd1);
        end
        if (v.width >= 1 && v.width <= N) check_ain(tag, v.mult, v.width);
    endtask

    initial begin
        int s0, a0, lat, guard;

        //           mult wid mode pass err idx cyc start ack
        vecs[0] = '{17,  30, 0, 1'b1, 0, 0, L,   1, 1};
        vecs[1] = '{19,  30, 1, 1'b0, 2, 4, L,   1, 1};
        vecs[2] = '{89,  30, 2, 1'b0, 3, 0, L,   1, 1};
        vecs[3] = '{17,  0,  0, 1'b0, 1, 0, 0,   0, 0};
        vecs[4] = '{17,  31, 0, 1'b0, 1, 0, 0,   0, 0};
        vecs[5] = '{112, 3,  0, 1'b1, 0, 0, L,   1, 1};
        vecs[6] = '{126, 10, 0, 1'b1, 0, 0, L,   1, 1};
        vecs[7] = '{5,   1,  0, 1'b1, 0, 0, L,   1, 1};
        vecs[8] = '{3,   4,  3, 1'b0, 4, 0, TO,  1, 0};

        // reset block
        #1;
        check("rst_ain",  32'(Ain == '0), 32'd1);
        check("rst_flags", 32'({Start, Ack, Busy, Pass, Fail}), 32'd0);
        check("rst_err",  32'(ErrCode), 32'd0);
        check("rst_cyc",  32'(Cycles), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Go while busy must be ignored
        s0 = start_cnt;
        model_mode  = 0;
        model_width = 30;
        pulse_go(17, 30);
        repeat (4) @(negedge Clk);
        check("busy_high", 32'(Busy), 32'd1);
        Mult = W'(3); Width = 5'd0; Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
        wait_result("busygo", lat);
        check("busygo_pass", 32'(Pass), 32'd1);
        check("busygo_err",  32'(ErrCode), 32'd0);
        check("busygo_start", 32'(start_cnt - s0), 32'd1);
        check("busygo_e0",  32'(Ain[0*W +: W]), 32'd17);
        check("busygo_e6",  32'(Ain[6*W +: W]), 32'd6);
        check("busygo_e29", 32'(Ain[29*W +: W]), 32'd58);

        // reset during WAIT
        a0 = ack_cnt;
        model_mode  = 3;
        model_width = 30;
        pulse_go(17, 30);
        guard = 0;
        while (DbgState != 3'd3 && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        check("rstw_reached_wait", 32'(DbgState), 32'd3);
        repeat (5) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("rstw_ain",   32'(Ain == '0), 32'd1);
        check("rstw_flags", 32'({Start, Ack, Busy, Pass, Fail}), 32'd0);
        check("rstw_err",   32'({ErrCode, ErrIdx}), 32'd0);
        check("rstw_cyc",   32'(Cycles), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        check("rstw_noack", 32'(ack_cnt - a0), 32'd0);
        run_vec('{120, 1, 0, 1'b1, 0, 0, L, 1, 1}, "post_rst");
        check("post_rst_e0", 32'(Ain[0*W +: W]), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
